// File: rtl/spi_txn_scheduler.sv
// Command/response scheduler in front of an SPI master: issues one frame per
// command, captures recvData on CS rise, enforces an inter-frame gap and a watchdog.
module spi_txn_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic                  spi_sendStart,
  output logic [DATA_WIDTH-1:0] spi_sendData,
  input  logic                  spi_cs,
  input  logic [DATA_WIDTH-1:0] spi_recvData
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CS_LO,
    BUSY,
    DONE,
    GAP,
    RESP
  } state_t;

  state_t          state;
  logic            csMeta;
  logic            csSync;
  logic [WD_W-1:0] wdCnt;
  logic [7:0]      gapCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_timeout   <= 1'b0;
      spi_sendStart <= 1'b0;
      spi_sendData  <= '0;
      csMeta        <= 1'b1;
      csSync        <= 1'b1;
      wdCnt         <= '0;
      gapCnt        <= '0;
    end else begin
      csMeta <= spi_cs;
      csSync <= csMeta;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            spi_sendData  <= cmd_data;
            spi_sendStart <= 1'b1;
            cmd_ready     <= 1'b0;
            wdCnt         <= '0;
            state         <= WAIT_CS_LO;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WAIT_CS_LO: begin
          if (!csSync) begin
            wdCnt <= '0;
            state <= BUSY;
          end else if (wdCnt == WD_LAST) begin
            spi_sendStart <= 1'b0;
            rsp_data      <= '0;
            rsp_timeout   <= 1'b1;
            gapCnt        <= '0;
            state         <= GAP;
          end else begin
            wdCnt <= wdCnt + 1'b1;
          end
        end
        BUSY: begin
          if (csSync) begin
            spi_sendStart <= 1'b0;
            gapCnt        <= '0;
            state         <= DONE;
          end else if (wdCnt == WD_LAST) begin
            spi_sendStart <= 1'b0;
            rsp_data      <= '0;
            rsp_timeout   <= 1'b1;
            gapCnt        <= '0;
            state         <= GAP;
          end else begin
            wdCnt <= wdCnt + 1'b1;
          end
        end
        DONE: begin
          // sendStart is already low here, so DONE counts as the first gap cycle
          rsp_data    <= spi_recvData;
          rsp_timeout <= 1'b0;
          gapCnt      <= 8'd1;
          state       <= GAP;
        end
        GAP: begin
          if (gapCnt >= GAP_LAST) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (gapCnt != '1) begin
            gapCnt <= gapCnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench: instance A uses default timing, instance B a 16-cycle watchdog.
module tb_spi_txn_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmdValid = 1'b0, cmdReady, rspValid, rspReady = 1'b0, rspTimeout;
  logic        sendStart, cs = 1'b1;
  logic [31:0] cmdData = '0, rspData, sendData, recvData = '0;

  logic        cmdValidB = 1'b0, cmdReadyB, rspValidB, rspReadyB = 1'b0, rspTimeoutB;
  logic        sendStartB, csB = 1'b1;
  logic [31:0] cmdDataB = '0, rspDataB, sendDataB, recvDataB = '0;

  int checks = 0;
  int errors = 0;

  spi_txn_scheduler #(.DATA_WIDTH(32), .GAP_CYCLES(4), .TIMEOUT_CYCLES(1024)) dutA (
    .clk(clk), .rst(rst),
    .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_data(cmdData),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_data(rspData), .rsp_timeout(rspTimeout),
    .spi_sendStart(sendStart), .spi_sendData(sendData),
    .spi_cs(cs), .spi_recvData(recvData)
  );

  spi_txn_scheduler #(.DATA_WIDTH(32), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dutB (
    .clk(clk), .rst(rst),
    .cmd_valid(cmdValidB), .cmd_ready(cmdReadyB), .cmd_data(cmdDataB),
    .rsp_valid(rspValidB), .rsp_ready(rspReadyB), .rsp_data(rspDataB), .rsp_timeout(rspTimeoutB),
    .spi_sendStart(sendStartB), .spi_sendData(sendDataB),
    .spi_cs(csB), .spi_recvData(recvDataB)
  );

  // Low-run monitor for sendStart between consecutive frames on instance A
  logic gapMon = 1'b0;
  logic sawHigh = 1'b0;
  int   lowRun = 0;
  int   minLow = 999;
  always @(negedge clk) begin
    if (gapMon) begin
      if (sendStart) begin
        if (sawHigh && lowRun > 0 && lowRun < minLow) minLow = lowRun;
        sawHigh = 1'b1;
        lowRun  = 0;
      end else begin
        lowRun++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sigSel(input int sel);
    case (sel)
      0:       return rspValid;
      1:       return sendStart;
      2:       return rspValidB;
      default: return sendStartB;
    endcase
  endfunction

  task automatic waitSig(input int sel, input logic lvl, input int limit, input string tag);
    int n = 0;
    while (sigSel(sel) !== lvl && n < limit) begin
      tick();
      n++;
    end
    check(tag, {31'd0, sigSel(sel)}, {31'd0, lvl});
  endtask

  task automatic frameB(input logic [31:0] cmd, input logic [31:0] echo, input string tag);
    cmdValidB = 1'b1;
    cmdDataB  = cmd;
    tick();
    cmdValidB = 1'b0;
    repeat (2) tick();
    csB       = 1'b0;
    recvDataB = echo;
    repeat (5) tick();
    csB = 1'b1;
    waitSig(2, 1'b1, 20, {tag, " rsp"});
    check({tag, " data"}, rspDataB, echo);
    check({tag, " tmo"}, {31'd0, rspTimeoutB}, 32'd0);
    rspReadyB = 1'b1;
    tick();
    rspReadyB = 1'b0;
  endtask

  initial begin
    int bad;

    // Reset state
    repeat (2) tick();
    check("rst cmdReady", {31'd0, cmdReady}, 0);
    check("rst rspValid", {31'd0, rspValid}, 0);
    check("rst sendStart", {31'd0, sendStart}, 0);
    check("rst sendData", sendData, 0);
    check("rst rspData", rspData, 0);
    check("rst rspTimeout", {31'd0, rspTimeout}, 0);
    rst = 1'b0;
    tick();
    check("idle cmdReady", {31'd0, cmdReady}, 1);
    check("idle cmdReadyB", {31'd0, cmdReadyB}, 1);

    // 1: nominal frame, CS low 70 cycles
    cmdValid = 1'b1;
    cmdData  = 32'hA5A5_1234;
    tick();
    cmdValid = 1'b0;
    cmdData  = '0;
    check("t1 start", {31'd0, sendStart}, 1);
    check("t1 sendData", sendData, 32'hA5A5_1234);
    check("t1 cmdReady", {31'd0, cmdReady}, 0);
    repeat (3) tick();
    cs       = 1'b0;
    recvData = 32'h0F0F_F0F0;
    bad = 0;
    repeat (70) begin
      tick();
      if (!sendStart) bad++;
    end
    check("t1 held", bad, 0);
    cs = 1'b1;
    repeat (2) tick();
    check("t1 start at sync", {31'd0, sendStart}, 1);
    tick();
    check("t1 start drop", {31'd0, sendStart}, 0);
    repeat (3) tick();
    check("t1 rsp early", {31'd0, rspValid}, 0);
    tick();
    check("t1 rsp valid", {31'd0, rspValid}, 1);
    check("t1 rsp data", rspData, 32'h0F0F_F0F0);
    check("t1 rsp tmo", {31'd0, rspTimeout}, 0);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    check("t1 rsp taken", {31'd0, rspValid}, 0);
    check("t1 ready back", {31'd0, cmdReady}, 1);

    // 2: backpressure with a second command queued
    cmdValid = 1'b1;
    cmdData  = 32'h1111_2222;
    tick();
    cmdValid = 1'b0;
    repeat (2) tick();
    cs       = 1'b0;
    recvData = 32'h3333_4444;
    repeat (10) tick();
    cs       = 1'b1;
    cmdValid = 1'b1;
    cmdData  = 32'h5555_6666;
    waitSig(0, 1'b1, 20, "t2 rsp1 wait");
    for (int i = 0; i < 50; i++) begin
      check("t2 hold valid", {31'd0, rspValid}, 1);
      check("t2 hold data", rspData, 32'h3333_4444);
      check("t2 hold ready", {31'd0, cmdReady}, 0);
      check("t2 no start", {31'd0, sendStart}, 0);
      tick();
    end
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    check("t2 rsp1 taken", {31'd0, rspValid}, 0);
    check("t2 no early start", {31'd0, sendStart}, 0);
    check("t2 idle ready", {31'd0, cmdReady}, 1);
    tick();
    cmdValid = 1'b0;
    check("t2 frame2 start", {31'd0, sendStart}, 1);
    check("t2 frame2 data", sendData, 32'h5555_6666);
    repeat (2) tick();
    cs       = 1'b0;
    recvData = 32'h7777_8888;
    repeat (10) tick();
    cs = 1'b1;
    waitSig(0, 1'b1, 20, "t2 rsp2 wait");
    check("t2 rsp2 data", rspData, 32'h7777_8888);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;

    // 5: reset while in BUSY
    cmdValid = 1'b1;
    cmdData  = 32'h2468_ACE0;
    tick();
    cmdValid = 1'b0;
    repeat (2) tick();
    cs       = 1'b0;
    recvData = 32'h9999_AAAA;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cs  = 1'b1;
    check("t5 start off", {31'd0, sendStart}, 0);
    check("t5 rsp off", {31'd0, rspValid}, 0);
    check("t5 ready off", {31'd0, cmdReady}, 0);
    tick();
    check("t5 ready on", {31'd0, cmdReady}, 1);
    bad = 0;
    repeat (20) begin
      tick();
      if (rspValid) bad++;
    end
    check("t5 no stale rsp", bad, 0);

    // 6: back-to-back frames, rspReady tied high
    gapMon   = 1'b1;
    rspReady = 1'b1;
    cmdValid = 1'b1;
    cmdData  = 32'hBBBB_0001;
    for (int k = 0; k < 2; k++) begin
      waitSig(1, 1'b1, 20, "t6 start wait");
      if (k == 1) cmdValid = 1'b0;
      repeat (2) tick();
      cs = 1'b0;
      repeat (8) tick();
      cs = 1'b1;
      waitSig(1, 1'b0, 20, "t6 end wait");
    end
    repeat (10) tick();
    gapMon   = 1'b0;
    rspReady = 1'b0;
    check("t6 min gap", minLow, 6);

    // 4: CS stuck low on instance B (16-cycle watchdog)
    frameB(32'h0000_0001, 32'hDEAD_BEEF, "t4 pre");
    cmdValidB = 1'b1;
    cmdDataB  = 32'h0000_0004;
    tick();
    cmdValidB = 1'b0;
    csB       = 1'b0;
    repeat (18) tick();
    check("t4 busy start", {31'd0, sendStartB}, 1);
    tick();
    check("t4 abort", {31'd0, sendStartB}, 0);
    repeat (3) tick();
    check("t4 rsp early", {31'd0, rspValidB}, 0);
    tick();
    check("t4 rsp valid", {31'd0, rspValidB}, 1);
    check("t4 rsp tmo", {31'd0, rspTimeoutB}, 1);
    check("t4 rsp data", rspDataB, 0);
    csB       = 1'b1;
    rspReadyB = 1'b1;
    tick();
    rspReadyB = 1'b0;
    check("t4 rsp taken", {31'd0, rspValidB}, 0);
    check("t4 ready back", {31'd0, cmdReadyB}, 1);

    // 3: CS never falls on instance B
    frameB(32'h0000_0002, 32'hCAFE_F00D, "t3 pre");
    cmdValidB = 1'b1;
    cmdDataB  = 32'h0000_0003;
    tick();
    cmdValidB = 1'b0;
    repeat (15) tick();
    check("t3 wait start", {31'd0, sendStartB}, 1);
    tick();
    check("t3 abort", {31'd0, sendStartB}, 0);
    repeat (3) tick();
    check("t3 rsp early", {31'd0, rspValidB}, 0);
    tick();
    check("t3 rsp valid", {31'd0, rspValidB}, 1);
    check("t3 rsp tmo", {31'd0, rspTimeoutB}, 1);
    check("t3 rsp data", rspDataB, 0);
    rspReadyB = 1'b1;
    tick();
    rspReadyB = 1'b0;
    check("t3 ready back", {31'd0, cmdReadyB}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/spi_txn_scheduler.md
Name: spi_txn_scheduler

Overview:
- Upstream and downstream companion to the SPI master.
- Accepts 32-bit command words over a valid/ready handshake and drives the master's level-sensitive sendStart/sendData interface, holding sendStart through each frame.
- Detects frame completion from SPI_CS, captures recvData and returns it over a valid/ready response port.
- Enforces an inter-frame gap and a watchdog timeout so a stuck master cannot hang the command stream.

Parameters:
- DATA_WIDTH, 32: command/response word width; must match the master's sendData/recvData width.
- GAP_CYCLES, 4: minimum clk cycles with sendStart low between frames; legal range 1..255.
- TIMEOUT_CYCLES, 1024: watchdog limit per phase (CS fall wait, CS rise wait); legal range 2..65535.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command word present.
- cmd_ready  output  1  scheduler accepts a command this cycle.
- cmd_data  input  DATA_WIDTH  word to transmit.
- rsp_valid  output  1  response word present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  DATA_WIDTH  word captured from the master's recvData.
- rsp_timeout  output  1  qualifies rsp_data: 1 means the frame aborted on the watchdog.
- spi_sendStart  output  1  to the master's sendStart.
- spi_sendData  output  DATA_WIDTH  to the master's sendData; registered, stable for the whole frame.
- spi_cs  input  1  the master's SPI_CS (active low).
- spi_recvData  input  DATA_WIDTH  the master's recvData.

Behaviour:
- Reset (rst=1 on a clk edge) forces:
  - state IDLE, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_timeout=0;
  - spi_sendStart=0, spi_sendData=0, all counters 0.
  - Reset mid-frame drops spi_sendStart on the next edge; no response is produced for the aborted frame.
- Input spi_cs is double-flopped before use. spi_recvData is sampled only as described under DONE.
- States and transitions:
  - IDLE: cmd_ready=1.
    - On cmd_valid&&cmd_ready: latch cmd_data into spi_sendData, set spi_sendStart=1, clear the watchdog, go to WAIT_CS_LO.
    - spi_sendStart rises on the cycle after the handshake.
  - WAIT_CS_LO: cmd_ready=0, spi_sendStart=1, watchdog increments every cycle.
    - Synced cs==0: clear the watchdog, go to BUSY.
    - Watchdog reaches TIMEOUT_CYCLES-1: set the timeout flag, go to GAP.
  - BUSY: spi_sendStart=1.
    - Synced cs==1: go to DONE.
    - Watchdog reaches TIMEOUT_CYCLES-1: set the timeout flag, go to GAP.
  - DONE: one cycle.
    - Capture spi_recvData into rsp_data, rsp_timeout=0, go to GAP.
  - GAP: spi_sendStart=0, gap counter counts GAP_CYCLES cycles.
    - On expiry: go to RESP.
    - On a timeout path, rsp_data is set to 0 and rsp_timeout=1.
  - RESP: rsp_valid=1, rsp_data and rsp_timeout held stable.
    - On rsp_valid&&rsp_ready: rsp_valid=0 on the next edge, go to IDLE.
- Latency:
  - Command handshake to spi_sendStart high: 1 cycle.
  - Synced CS rising to rsp_valid: GAP_CYCLES+1 cycles.
  - Minimum cycles between command handshakes: frame time + 4 + GAP_CYCLES.
- Backpressure:
  - rsp_ready low holds RESP indefinitely.
  - cmd_ready stays 0 until the response is accepted, so there is exactly one transaction in flight.
- Simultaneous events:
  - In RESP, rsp_ready and a pending cmd_valid in the same cycle: the response is consumed; the command is accepted no earlier than the following IDLE cycle.
  - In WAIT_CS_LO or BUSY, a watchdog expiry and a CS transition in the same cycle: the CS transition wins.
- Glitch handling: a CS low pulse shorter than the sync depth may be missed; the watchdog then aborts the frame cleanly.
- Counter widths:
  - Watchdog: $clog2(TIMEOUT_CYCLES) bits.
  - Gap counter: 8 bits.
  - Both saturate and never wrap.

Test Plan:
1. Nominal frame. Reset, then cmd 0xA5A5_1234 with a master model echoing recvData=0x0F0F_F0F0 (CS low 70 cycles). Required:
   - spi_sendStart high from handshake+1 until CS rise +1;
   - rsp_valid 5 cycles after synced CS rise, rsp_data=0x0F0F_F0F0, rsp_timeout=0.
2. Backpressure and ordering. Two queued commands, rsp_ready held low for 50 cycles. Required:
   - rsp_valid and rsp_data stable for all 50 cycles;
   - cmd_ready=0 throughout;
   - second frame starts only after the first response is accepted.
3. CS never falls. Master model ignores sendStart, TIMEOUT_CYCLES=16. Required:
   - sendStart drops after 16 cycles in WAIT_CS_LO;
   - response with rsp_timeout=1, rsp_data=0;
   - cmd_ready returns to 1 afterwards.
4. CS stuck low. Required: BUSY watchdog aborts at TIMEOUT_CYCLES and a timeout response is produced.
5. Reset mid-frame. Assert rst for 1 cycle while in BUSY. Required:
   - next edge: spi_sendStart=0, rsp_valid=0, cmd_ready=0;
   - the following cycle: IDLE with cmd_ready=1;
   - no stale response.
6. Gap enforcement. Back-to-back commands with rsp_ready tied high, GAP_CYCLES=4. Required: spi_sendStart low for at least 6 cycles between frames (4 GAP + RESP + IDLE), confirmed by a bench checker.
